// File: rtl/down_timer_4b.sv
// Loadable down-counter with one-shot / auto-reload modes and a cascadable
// combinational terminal-count output.
module down_timer_4b #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cten,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             auto,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, done_q;
  logic             expiry;

  // An expiry is a pending zero-count in RUN; ld takes precedence and suppresses it.
  assign expiry = (state_q == RUN) && (cnt_q == '0) && cten && !ld;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (ld) begin
      cnt_d    = din;
      reload_d = din;
      state_d  = RUN;
    end else if (cten && (state_q == RUN)) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else if (auto) begin
        cnt_d = reload_q;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign out  = cnt_q;
  assign tc   = expiry;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_timer_4b.sv
// Bench for down_timer_4b: behavioural model compared every cycle, directed
// scenarios with literal expectations, randomized traffic and a two-stage cascade.
module tb_down_timer_4b;

  logic       clk = 1'b0;
  logic       clr, cten, ld, auto;
  logic [3:0] din;
  logic [3:0] out;
  logic       tc, busy, done;

  logic       c_clr, c_ld;
  logic [3:0] lo_out, hi_out;
  logic       lo_tc, lo_busy, lo_done, hi_tc, hi_busy, hi_done;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // model: mode 0 = idle, 1 = running, 2 = finished
  int m_mode = 0;
  int m_cnt  = 0;
  int m_rel  = 0;

  always #5 clk = ~clk;

  down_timer_4b #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .cten(cten), .ld(ld), .din(din), .auto(auto),
    .out(out), .tc(tc), .busy(busy), .done(done)
  );

  down_timer_4b #(.WIDTH(4)) u_lo (
    .clk(clk), .clr(c_clr), .cten(1'b1), .ld(c_ld), .din(4'd15), .auto(1'b1),
    .out(lo_out), .tc(lo_tc), .busy(lo_busy), .done(lo_done)
  );

  down_timer_4b #(.WIDTH(4)) u_hi (
    .clk(clk), .clr(c_clr), .cten(lo_tc), .ld(c_ld), .din(4'd15), .auto(1'b1),
    .out(hi_out), .tc(hi_tc), .busy(hi_busy), .done(hi_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_mode = 0;
      m_cnt  = 0;
      m_rel  = 0;
    end else if (ld) begin
      m_cnt  = int'(din);
      m_rel  = int'(din);
      m_mode = 1;
    end else if (cten && m_mode == 1) begin
      if (m_cnt > 0)   m_cnt = m_cnt - 1;
      else if (auto)   m_cnt = m_rel;
      else             m_mode = 2;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_out", 32'(out), 32'(m_cnt));
      chk("model_tc", 32'(tc), 32'(m_mode == 1 && m_cnt == 0 && cten && !ld && !clr));
      chk("model_busy", 32'(busy), 32'(m_mode == 1));
      chk("model_done", 32'(done), 32'(m_mode == 2));
    end
  end

  task automatic step(input logic c, input logic l, input logic a, input logic [3:0] d);
    @(posedge clk);
    #2;
    cten = c; ld = l; auto = a; din = d;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int first_k, second_k, n_hits;
    bit busy_ok;
    logic [3:0] os_out [5]  = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    logic       os_tc  [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       os_dn  [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] ar_out [7]  = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
    logic       ar_tc  [7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       eg_en  [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] eg_out [4]  = '{4'd4, 4'd3, 4'd3, 4'd2};

    clr = 1'b1; c_clr = 1'b1; cten = 1'b0; ld = 1'b0; auto = 1'b0; din = '0; c_ld = 1'b0;
    #23;
    chk("rst_out", 32'(out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk); #2;
    clr = 1'b0; c_clr = 1'b0;
    cmp_en = 1'b1;

    // idle ignores cten
    step(1, 0, 0, 4'd7);
    step(1, 0, 0, 4'd7);
    chk("idle_out", 32'(out), 0);
    chk("idle_tc", 32'(tc), 0);

    // one-shot from 3
    step(1, 1, 0, 4'd3);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 4'd0);
      chk($sformatf("os_out%0d", i), 32'(out), 32'(os_out[i]));
      chk($sformatf("os_tc%0d", i), 32'(tc), 32'(os_tc[i]));
      chk($sformatf("os_done%0d", i), 32'(done), 32'(os_dn[i]));
    end
    step(1, 0, 0, 4'd0);
    chk("done_tc_hold", 32'(tc), 0);

    // auto-reload from 2
    step(1, 1, 1, 4'd2);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 1, 4'd0);
      chk($sformatf("ar_out%0d", i), 32'(out), 32'(ar_out[i]));
      chk($sformatf("ar_tc%0d", i), 32'(tc), 32'(ar_tc[i]));
      chk($sformatf("ar_busy%0d", i), 32'(busy), 1);
    end

    // enable gating from 4
    step(1, 1, 0, 4'd4);
    for (int i = 0; i < 4; i++) begin
      step(eg_en[i], 0, 0, 4'd0);
      chk($sformatf("eg_out%0d", i), 32'(out), 32'(eg_out[i]));
      chk($sformatf("eg_tc%0d", i), 32'(tc), 0);
    end

    // load of zero: immediate expiry then done
    step(1, 1, 0, 4'd0);
    step(1, 0, 0, 4'd0);
    chk("z_tc", 32'(tc), 1);
    step(1, 0, 0, 4'd0);
    chk("z_done", 32'(done), 1);
    chk("z_tc_after", 32'(tc), 0);

    // collision of ld with pending expiry
    step(1, 1, 0, 4'd1);
    step(1, 0, 0, 4'd0);
    step(1, 1, 0, 4'd9);
    chk("col_out", 32'(out), 0);
    chk("col_tc", 32'(tc), 0);
    step(1, 0, 0, 4'd0);
    chk("col_next_out", 32'(out), 9);
    chk("col_busy", 32'(busy), 1);

    // asynchronous clear mid-run at 5
    step(0, 1, 0, 4'd5);
    step(1, 0, 0, 4'd0);
    chk("ar5_out", 32'(out), 5);
    #2 clr = 1'b1;
    #1;
    chk("aclr_out", 32'(out), 0);
    chk("aclr_busy", 32'(busy), 0);
    chk("aclr_done", 32'(done), 0);
    chk("aclr_tc", 32'(tc), 0);
    @(posedge clk); #2 clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 4'd0);
      chk($sformatf("post_clr_busy%0d", i), 32'(busy), 0);
      chk($sformatf("post_clr_out%0d", i), 32'(out), 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic rc, rl, ra;
      logic [3:0] rd;
      rc = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 9) == 0);
      ra = $urandom_range(0, 1) == 1;
      rd = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step(rc, rl, ra, rd);
      if ($urandom_range(0, 99) == 0) begin
        #1 clr = 1'b1;
        @(posedge clk); #2 clr = 1'b0;
      end
    end
    cmp_en = 1'b0;

    // two-stage cascade: combined period 256
    @(posedge clk); #2 c_ld = 1'b1;
    @(posedge clk); #2 c_ld = 1'b0;
    first_k = -1; second_k = -1; n_hits = 0; busy_ok = 1'b1;
    for (int k = 0; k < 600 && n_hits < 2; k++) begin
      @(negedge clk); #1;
      if (k == 16) chk("casc_hi_after16", 32'(hi_out), 14);
      if (!hi_busy) busy_ok = 1'b0;
      if (hi_tc) begin
        if (n_hits == 0) first_k = k; else second_k = k;
        n_hits++;
      end
    end
    chk("casc_first", 32'(first_k), 255);
    chk("casc_second", 32'(second_k), 511);
    chk("casc_busy", 32'(busy_ok), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
